// File: rtl/tx_sequence_recorder_if.sv
// ----------------------------------------------------------------------------
// tx_sequence_recorder_if
// Push/pop bus between the TX arbiter edge detector (master side, pushes IDs),
// the grant logic (master side, pops IDs) and the ordering FIFO (slave side).
// Optional macro TX_SEQ_REC_WATERMARK_EN adds the high-water-mark signals
// wm_clr and max_count.
// ----------------------------------------------------------------------------
interface tx_sequence_recorder_if #(
    parameter int DATA_WIDTH = 3,
    parameter int CNT_WIDTH  = 4
);
    // push side
    logic                  wr_en;
    logic [2:0]            wr_mode;
    logic [DATA_WIDTH-1:0] wr_data_1;
    logic [DATA_WIDTH-1:0] wr_data_2;
    logic [DATA_WIDTH-1:0] wr_data_3;
    logic [DATA_WIDTH-1:0] wr_data_4;
    // pop side
    logic                  rd_en;
    logic [1:0]            rd_mode;
    logic [DATA_WIDTH-1:0] rd_data_1;
    logic [DATA_WIDTH-1:0] rd_data_2;
    // status
    logic                  empty;
    logic                  full;
    logic [CNT_WIDTH-1:0]  available;
    logic [CNT_WIDTH-1:0]  count;
    logic                  wr_err;
    logic                  rd_err;
`ifdef TX_SEQ_REC_WATERMARK_EN
    logic                  wm_clr;
    logic [CNT_WIDTH-1:0]  max_count;

    modport master (
        output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4,
        output rd_en, rd_mode, wm_clr,
        input  rd_data_1, rd_data_2, empty, full, available, count,
        input  wr_err, rd_err, max_count
    );

    modport slave (
        input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4,
        input  rd_en, rd_mode, wm_clr,
        output rd_data_1, rd_data_2, empty, full, available, count,
        output wr_err, rd_err, max_count
    );
`else
    modport master (
        output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4,
        output rd_en, rd_mode,
        input  rd_data_1, rd_data_2, empty, full, available, count,
        input  wr_err, rd_err
    );

    modport slave (
        input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4,
        input  rd_en, rd_mode,
        output rd_data_1, rd_data_2, empty, full, available, count,
        output wr_err, rd_err
    );
`endif
endinterface

// File: rtl/tx_sequence_recorder.sv
// ----------------------------------------------------------------------------
// tx_sequence_recorder
// Multi-push (1..4) / multi-pop (1..2) show-ahead ordering FIFO recording which
// TX source raised a new request, in arrival order. Source ID encoding:
// NO_SOURCE=0, A2P_1=1, A2P_2=2, MASTER=3, RX_ROUTER_CFG=4, RX_ROUTER_ERR=5.
// FIFO_DEPTH need not be a power of two; pointers wrap by compare-and-subtract.
// Bursts are all-or-nothing: a write that does not fit in the pre-edge free
// space is dropped whole (wr_err pulse), a read asking for more than the
// pre-edge occupancy is refused (rd_err pulse).
// Optional macro TX_SEQ_REC_WATERMARK_EN adds a high-water mark (max_count)
// with a synchronous clear (wm_clr).
// ----------------------------------------------------------------------------
module tx_sequence_recorder #(
    parameter int DATA_WIDTH = 3,
    parameter int FIFO_DEPTH = 10,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   arst,
    tx_sequence_recorder_if.slave  bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Comparison width wide enough for both a 3-bit mode and a count
    localparam int CMP_W = CNT_WIDTH + 3;

    localparam logic [DATA_WIDTH-1:0] NO_SOURCE = '0;
    localparam logic [CNT_WIDTH-1:0]  DEPTH_C   = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [PTR_W:0]        DEPTH_P   = (PTR_W + 1)'(FIFO_DEPTH);

    // Storage and control state
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  wr_err;
    logic                  rd_err;

    // Decoded request and next-state signals
    logic [DATA_WIDTH-1:0] wr_data [4];
    logic [PTR_W-1:0]      wr_idx  [4];
    logic [CNT_WIDTH-1:0]  available;
    logic                  wr_mode_ok;
    logic                  rd_mode_ok;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  wr_reject;
    logic                  rd_reject;
    logic [2:0]            wr_amt;
    logic [1:0]            rd_amt;
    logic [CNT_WIDTH:0]    cnt_sum;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_next;

    // Modulo-FIFO_DEPTH pointer advance; k never exceeds 4 <= FIFO_DEPTH, so a
    // single conditional subtract is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [2:0]       k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W + 1)'(k);
        if (s >= DEPTH_P) begin
            s = s - DEPTH_P;
        end
        return s[PTR_W-1:0];
    endfunction

    assign wr_data[0] = bus.wr_data_1;
    assign wr_data[1] = bus.wr_data_2;
    assign wr_data[2] = bus.wr_data_3;
    assign wr_data[3] = bus.wr_data_4;

    // Free slots derive only from the registered count
    assign available = DEPTH_C - count;

    // Request qualification against pre-edge count/available
    always_comb begin
        wr_mode_ok = (bus.wr_mode >= 3'd1) && (bus.wr_mode <= 3'd4);
        rd_mode_ok = (bus.rd_mode == 2'd1) || (bus.rd_mode == 2'd2);
        wr_accept  = 1'b0;
        wr_reject  = 1'b0;
        rd_accept  = 1'b0;
        rd_reject  = 1'b0;
        if (bus.wr_en && wr_mode_ok) begin
            if (CMP_W'(bus.wr_mode) <= CMP_W'(available)) begin
                wr_accept = 1'b1;
            end else begin
                wr_reject = 1'b1;
            end
        end
        if (bus.rd_en && rd_mode_ok) begin
            if (CMP_W'(bus.rd_mode) <= CMP_W'(count)) begin
                rd_accept = 1'b1;
            end else begin
                rd_reject = 1'b1;
            end
        end
        wr_amt = wr_accept ? bus.wr_mode : 3'd0;
        rd_amt = rd_accept ? bus.rd_mode : 2'd0;
    end

    // Next occupancy and pointers; acceptance rules keep the result in range
    always_comb begin
        cnt_sum     = {1'b0, count} + (CNT_WIDTH + 1)'(wr_amt)
                    - (CNT_WIDTH + 1)'(rd_amt);
        count_next  = cnt_sum[CNT_WIDTH-1:0];
        wr_ptr_next = ptr_add(wr_ptr, wr_amt);
        rd_ptr_next = ptr_add(rd_ptr, {1'b0, rd_amt});
        for (int i = 0; i < 4; i++) begin
            wr_idx[i] = ptr_add(wr_ptr, 3'(i));
        end
    end

    // Burst write into storage; storage is data and carries no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_accept && (3'(i) < bus.wr_mode)) begin
                mem[wr_idx[i]] <= wr_data[i];
            end
        end
    end

    // Pointer, occupancy and error-pulse registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            wr_err <= wr_reject;
            rd_err <= rd_reject;
        end
    end

    // Show-ahead read ports and status decode, all from registered state
    always_comb begin
        bus.rd_data_1 = (count == '0) ? NO_SOURCE : mem[rd_ptr];
        bus.rd_data_2 = (count >= CNT_WIDTH'(2)) ? mem[ptr_add(rd_ptr, 3'd1)]
                                                 : NO_SOURCE;
        bus.empty     = (count == '0);
        bus.full      = (count == DEPTH_C);
        bus.available = available;
        bus.count     = count;
        bus.wr_err    = wr_err;
        bus.rd_err    = rd_err;
    end

`ifdef TX_SEQ_REC_WATERMARK_EN
    logic [CNT_WIDTH-1:0] max_count;

    // High-water mark; a clear restarts tracking from the incoming count
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            max_count <= '0;
        end else if (bus.wm_clr) begin
            max_count <= count_next;
        end else if (count_next > max_count) begin
            max_count <= count_next;
        end
    end

    assign bus.max_count = max_count;
`endif

endmodule

// File: tb/tb_tx_sequence_recorder.sv
// ----------------------------------------------------------------------------
// tb_tx_sequence_recorder
// Directed bench for tx_sequence_recorder (FIFO_DEPTH=10, DATA_WIDTH=3).
// ----------------------------------------------------------------------------
module tb_tx_sequence_recorder;

    localparam int DATA_WIDTH = 3;
    localparam int FIFO_DEPTH = 10;
    localparam int CNT_WIDTH  = 4;

    logic clk;
    logic arst;

    int checks;
    int failures;

    tx_sequence_recorder_if #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    tx_sequence_recorder #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_mode   = 3'd0;
        bus.wr_data_1 = '0;
        bus.wr_data_2 = '0;
        bus.wr_data_3 = '0;
        bus.wr_data_4 = '0;
        bus.rd_en     = 1'b0;
        bus.rd_mode   = 2'd0;
    endtask

    // One clock with the given request; outputs are then sampled 1 ns after the edge
    task automatic op(input logic we, input logic [2:0] wm,
                      input logic [2:0] d1, input logic [2:0] d2,
                      input logic [2:0] d3, input logic [2:0] d4,
                      input logic re, input logic [1:0] rm);
        bus.wr_en     = we;
        bus.wr_mode   = wm;
        bus.wr_data_1 = d1;
        bus.wr_data_2 = d2;
        bus.wr_data_3 = d3;
        bus.wr_data_4 = d4;
        bus.rd_en     = re;
        bus.rd_mode   = rm;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push(input logic [2:0] wm, input logic [2:0] d1, input logic [2:0] d2,
                        input logic [2:0] d3, input logic [2:0] d4);
        op(1'b1, wm, d1, d2, d3, d4, 1'b0, 2'd0);
    endtask

    task automatic pop(input logic [1:0] rm);
        op(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, rm);
    endtask

    task automatic pulse_reset();
        #2;
        arst = 1'b0;
        #2;
        arst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
`ifdef TX_SEQ_REC_WATERMARK_EN
        bus.wm_clr = 1'b0;
`endif
        arst = 1'b1;
        #1;
        arst = 1'b0;
        #2;
        // Values while reset is held
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_count", bus.count, 0);
        #10;
        arst = 1'b1;
        @(posedge clk);
        #1;
        // Idle after reset
        check_eq("idle_empty", bus.empty, 1);
        check_eq("idle_full", bus.full, 0);
        check_eq("idle_avail", bus.available, 10);
        check_eq("idle_count", bus.count, 0);
        check_eq("idle_rd1", bus.rd_data_1, 0);
        check_eq("idle_rd2", bus.rd_data_2, 0);
        check_eq("idle_wr_err", bus.wr_err, 0);
        check_eq("idle_rd_err", bus.rd_err, 0);

        // Basic burst push / pop
        push(3'd4, 3'd1, 3'd2, 3'd3, 3'd5);
        check_eq("b_count", bus.count, 4);
        check_eq("b_avail", bus.available, 6);
        check_eq("b_rd1", bus.rd_data_1, 1);
        check_eq("b_rd2", bus.rd_data_2, 2);
        pop(2'd2);
        check_eq("b_pop1_rd1", bus.rd_data_1, 3);
        check_eq("b_pop1_rd2", bus.rd_data_2, 5);
        check_eq("b_pop1_count", bus.count, 2);
        pop(2'd2);
        check_eq("b_pop2_empty", bus.empty, 1);
        check_eq("b_pop2_rd1", bus.rd_data_1, 0);

        // No-op modes do nothing and raise no error
        op(1'b1, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 2'd3);
        check_eq("noop_count", bus.count, 0);
        check_eq("noop_wr_err", bus.wr_err, 0);
        check_eq("noop_rd_err", bus.rd_err, 0);

        // Wrap: pointers restart from 0
        pulse_reset();
        check_eq("wr_rst_count", bus.count, 0);
        push(3'd4, 3'd1, 3'd2, 3'd3, 3'd4);
        push(3'd4, 3'd5, 3'd1, 3'd2, 3'd3);
        check_eq("w_count8", bus.count, 8);
        pop(2'd2);
        check_eq("w_p1_rd1", bus.rd_data_1, 3);
        check_eq("w_p1_rd2", bus.rd_data_2, 4);
        pop(2'd2);
        check_eq("w_p2_rd1", bus.rd_data_1, 5);
        check_eq("w_p2_rd2", bus.rd_data_2, 1);
        pop(2'd2);
        check_eq("w_p3_rd1", bus.rd_data_1, 2);
        check_eq("w_p3_rd2", bus.rd_data_2, 3);
        push(3'd4, 3'd4, 3'd3, 3'd2, 3'd1);
        check_eq("w_count6", bus.count, 6);
        pop(2'd2);
        check_eq("w_p4_rd1", bus.rd_data_1, 4);
        check_eq("w_p4_rd2", bus.rd_data_2, 3);
        pop(2'd2);
        check_eq("w_p5_rd1", bus.rd_data_1, 2);
        check_eq("w_p5_rd2", bus.rd_data_2, 1);
        pop(2'd2);
        check_eq("w_drain_empty", bus.empty, 1);

        // Overflow: reject whole burst
        push(3'd4, 3'd1, 3'd1, 3'd1, 3'd1);
        push(3'd4, 3'd2, 3'd2, 3'd2, 3'd2);
        check_eq("o_count8", bus.count, 8);
        check_eq("o_avail2", bus.available, 2);
        push(3'd3, 3'd5, 3'd5, 3'd5, 3'd0);
        check_eq("o_wr_err", bus.wr_err, 1);
        check_eq("o_rej_count", bus.count, 8);
        op(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
        check_eq("o_wr_err_pulse", bus.wr_err, 0);
        push(3'd2, 3'd3, 3'd3, 3'd0, 3'd0);
        check_eq("o_full", bus.full, 1);
        check_eq("o_avail0", bus.available, 0);
        check_eq("o_count10", bus.count, 10);

        // Full: write rejected, read accepted in the same cycle
        op(1'b1, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
        check_eq("s_wr_err", bus.wr_err, 1);
        check_eq("s_rd_err", bus.rd_err, 0);
        check_eq("s_count8", bus.count, 8);
        check_eq("s_full", bus.full, 0);
        // At count 8: push 2 and pop 2 both accepted
        op(1'b1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd0, 1'b1, 2'd2);
        check_eq("s2_wr_err", bus.wr_err, 0);
        check_eq("s2_count8", bus.count, 8);
        check_eq("s2_rd1", bus.rd_data_1, 2);
        // Remaining order: 2,2,2,2,3,3,4,5
        pop(2'd2);
        pop(2'd2);
        check_eq("s2_rd_33", bus.rd_data_1 * 8 + bus.rd_data_2, 3 * 8 + 3);
        pop(2'd2);
        check_eq("s2_rd_45", bus.rd_data_1 * 8 + bus.rd_data_2, 4 * 8 + 5);
        check_eq("s2_full_rejected_not_stored", bus.count, 2);

        // Underflow
        pulse_reset();
        push(3'd1, 3'd5, 3'd0, 3'd0, 3'd0);
        check_eq("u_count1", bus.count, 1);
        check_eq("u_rd1", bus.rd_data_1, 5);
        check_eq("u_rd2", bus.rd_data_2, 0);
        pop(2'd2);
        check_eq("u_rd_err", bus.rd_err, 1);
        check_eq("u_count_kept", bus.count, 1);
        check_eq("u_rd2_zero", bus.rd_data_2, 0);
        pop(2'd1);
        check_eq("u_empty", bus.empty, 1);
        check_eq("u_rd_err_pulse", bus.rd_err, 0);

        // Empty: write accepted, read refused in the same cycle
        op(1'b1, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0, 1'b1, 2'd1);
        check_eq("e_rd_err", bus.rd_err, 1);
        check_eq("e_count1", bus.count, 1);
        check_eq("e_rd1", bus.rd_data_1, 3);

        // Asynchronous reset in the middle of a burst
        push(3'd4, 3'd1, 3'd2, 3'd3, 3'd4);
        check_eq("a_count5", bus.count, 5);
        bus.wr_en   = 1'b1;
        bus.wr_mode = 3'd4;
        #3;
        arst = 1'b0;
        #1;
        check_eq("a_count0", bus.count, 0);
        check_eq("a_empty", bus.empty, 1);
        check_eq("a_avail", bus.available, 10);
        check_eq("a_rd1", bus.rd_data_1, 0);
        idle_inputs();
        #10;
        arst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("a_after_count", bus.count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_sequence_recorder.md
Name: tx_sequence_recorder

Overview:
Multi-push/multi-pop ordering FIFO that sits directly downstream of the TX arbiter's positive-edge detector. Each cycle it records, in arrival order, up to 4 source IDs naming which TX source raised a new request. Sources are A2P_1, A2P_2, MASTER and RX_ROUTER_CFG/ERR. The TX arbiter's grant logic pops up to 2 IDs per cycle to decide which source's TLP is sent next.

Parameters:
- DATA_WIDTH, 3, width of one source ID. Encoding: NO_SOURCE=0, A2P_1=1, A2P_2=2, MASTER=3, RX_ROUTER_CFG=4, RX_ROUTER_ERR=5.
- FIFO_DEPTH, 10, number of entries; need not be a power of 2; minimum 4.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of occupancy and free-slot counts.

Ports:
- clk  in  1  rising-edge clock.
- arst  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_mode  in  3  number of IDs to push (1..4); 0 or >4 = no-op.
- wr_data_1..wr_data_4  in  DATA_WIDTH each  IDs to push; wr_data_1 is the oldest.
- rd_en  in  1  read request.
- rd_mode  in  2  number of IDs to pop (1..2); 0 or 3 = no-op.
- rd_data_1  out  DATA_WIDTH  head entry (show-ahead).
- rd_data_2  out  DATA_WIDTH  head+1 entry (show-ahead).
- empty  out  1  count==0.
- full  out  1  count==FIFO_DEPTH.
- available  out  CNT_WIDTH  free slots, FIFO_DEPTH-count.
- count  out  CNT_WIDTH  occupied slots.
- wr_err  out  1  one-cycle pulse: write burst rejected.
- rd_err  out  1  one-cycle pulse: read request rejected.

Behaviour:
- State: mem[FIFO_DEPTH], wr_ptr, rd_ptr, count, wr_err, rd_err; all registers except mem are reset asynchronously.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, wr_err=0, rd_err=0. Outputs then read empty=1, full=0, available=FIFO_DEPTH, rd_data_1/2=NO_SOURCE. mem is not cleared.
- Reset asserted mid-operation clears all state immediately. Pending entries are lost and outputs reach reset values with no clock edge.
- Write acceptance: wr_en && 1<=wr_mode<=4 && wr_mode<=available.
  - available is the pre-edge value; a same-cycle read does not free slots for this write.
  - On accept: mem[wr_ptr+i] <= wr_data_(i+1) for i=0..wr_mode-1; wr_ptr advances by wr_mode.
  - On reject (wr_mode>available): whole burst dropped, no partial write, wr_err=1 next cycle.
- Read acceptance: rd_en && 1<=rd_mode<=2 && rd_mode<=count (pre-edge).
  - On accept: rd_ptr advances by rd_mode.
  - On reject (rd_mode>count): no pop, rd_err=1 next cycle.
- Pointer arithmetic is modulo FIFO_DEPTH: ptr+k >= FIFO_DEPTH wraps to ptr+k-FIFO_DEPTH. Implement by compare-and-subtract, not bit truncation.
- count_next = count + (write accepted ? wr_mode : 0) - (read accepted ? rd_mode : 0).
  - Simultaneous accepted read and write in one cycle are both legal, including when full or empty per the pre-edge rules.
  - count never exceeds FIFO_DEPTH and never underflows.
- Read data: combinational from registered rd_ptr and mem; latency 0 from state, 1 cycle from write to visibility.
  - rd_data_1 = empty ? NO_SOURCE : mem[rd_ptr].
  - rd_data_2 = (count>=2) ? mem[rd_ptr+1 mod DEPTH] : NO_SOURCE.
- empty, full, available and count decode only from the count register; no combinational path from any input.
- Ordering: strict FIFO. Within a burst, wr_data_1 is popped before wr_data_2, and so on.

Optional Feature:
Macro TX_SEQ_REC_WATERMARK_EN.
- Defined: adds output max_count [CNT_WIDTH], a high-water mark.
  - Reset value 0.
  - Updated each cycle to max(max_count, count_next).
  - Cleared by an extra input wm_clr (1 bit, synchronous, active-high). wm_clr has priority over the update, and max_count then loads count_next.
- Undefined: max_count and wm_clr ports are absent; no added logic.

Test Plan:
- Reset then idle: empty=1, available=10, count=0, rd_data_1=rd_data_2=0, wr_err=rd_err=0.
- Push wr_mode=4 with IDs 1,2,3,5 → next cycle count=4, rd_data_1=1, rd_data_2=2. Pop rd_mode=2 twice → reads 1,2 then 3,5, then empty=1.
- Wrap: 2 pushes of 4, pop 6, then push 4 with IDs 4,3,2,1 → wr_ptr wraps from 8 to 2. Popped order is correct, count=6.
- Overflow: fill to count=8, push wr_mode=3 → rejected, wr_err pulses 1 cycle, count stays 8. Then push wr_mode=2 → full=1, available=0.
- Underflow: count=1, rd_mode=2 → rd_err pulse, count stays 1, rd_data_2=0. rd_mode=1 → empty=1.
- Simultaneous: full (count=10), push wr_mode=1 with rd_mode=2 in the same cycle → write rejected (wr_err), read accepted, count=8. Then arst low mid-burst → count=0 immediately.
